// File: rtl/mult_wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// mult_wb_arbiter_if
// Bundles the writeback-arbiter bus. Signal suffixes are written from the
// arbiter's point of view (_i = into the arbiter, _o = out of it).
//   mult_*   : result of the last multiplier stage (data, dest reg, enable, pc)
//   exe_*    : result of the single-cycle execute path (data, dest reg, enable, pc)
//   rf_*     : register-file write port (data, address, strobe)
//   wb_pc_o  : PC of the instruction being written back
//   exe_stall_o : execute stage must hold its outputs this cycle
// Modports: master = pipeline/bench side, slave = arbiter.
// ---------------------------------------------------------------------------
interface mult_wb_arbiter_if;
    logic [31:0] mult_int_write_data_i;
    logic [4:0]  mult_write_addr_i;
    logic        mult_int_write_enable_i;
    logic [31:0] mult_pc_i;
    logic [31:0] exe_int_write_data_i;
    logic [4:0]  exe_write_addr_i;
    logic        exe_int_write_enable_i;
    logic [31:0] exe_pc_i;
    logic [31:0] rf_write_data_o;
    logic [4:0]  rf_write_addr_o;
    logic        rf_write_enable_o;
    logic [31:0] wb_pc_o;
    logic        exe_stall_o;

    modport master (
        output mult_int_write_data_i, mult_write_addr_i, mult_int_write_enable_i, mult_pc_i,
        output exe_int_write_data_i, exe_write_addr_i, exe_int_write_enable_i, exe_pc_i,
        input  rf_write_data_o, rf_write_addr_o, rf_write_enable_o, wb_pc_o, exe_stall_o
    );

    modport slave (
        input  mult_int_write_data_i, mult_write_addr_i, mult_int_write_enable_i, mult_pc_i,
        input  exe_int_write_data_i, exe_write_addr_i, exe_int_write_enable_i, exe_pc_i,
        output rf_write_data_o, rf_write_addr_o, rf_write_enable_o, wb_pc_o, exe_stall_o
    );
endinterface

// File: rtl/mult_wb_arbiter.sv
// ---------------------------------------------------------------------------
// mult_wb_arbiter
// Shares one register-file write port between the multiplier and the execute
// path. The multiplier always wins; execute results that lose (or that would
// overtake older buffered execute results) wait in a 2-entry FIFO. When the
// FIFO is full the execute stage is stalled.
// Ports:
//   clk_i  : clock, all state updates on the rising edge
//   rsn_i  : synchronous reset, active-high
//   bus    : mult_wb_arbiter_if.slave (multiplier/execute inputs, RF write
//            port, writeback PC and execute stall)
// ---------------------------------------------------------------------------
module mult_wb_arbiter (
    input  logic             clk_i,
    input  logic             rsn_i,
    mult_wb_arbiter_if.slave bus
);
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              mult_live;
    logic              exe_live;
    logic              fifo_empty;
    logic              stall;
    logic              push;
    logic              pop;

    logic [1:0]        count_q, count_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;

    logic [DATA_W-1:0] fifo_data_q [2];
    logic [DATA_W-1:0] fifo_data_d [2];
    logic [ADDR_W-1:0] fifo_addr_q [2];
    logic [ADDR_W-1:0] fifo_addr_d [2];
    logic [DATA_W-1:0] fifo_pc_q   [2];
    logic [DATA_W-1:0] fifo_pc_d   [2];

    logic [DATA_W-1:0] rf_data_q, rf_data_d;
    logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
    logic              rf_we_q, rf_we_d;
    logic [DATA_W-1:0] wb_pc_q, wb_pc_d;

    // Stall depends only on registered occupancy, so it never loops back
    // through the execute inputs combinationally.
    assign stall = (count_q == 2'd2);

    always_comb begin
        // Writes to r0 are architecturally meaningless, so they are dropped.
        mult_live  = bus.mult_int_write_enable_i && (bus.mult_write_addr_i != '0);
        // While stalled, upstream is re-presenting an already-seen value.
        exe_live   = bus.exe_int_write_enable_i && (bus.exe_write_addr_i != '0) && !stall;
        fifo_empty = (count_q == 2'd0);

        pop  = !mult_live && !fifo_empty;
        // Buffer instead of writing directly whenever the port is taken or an
        // older execute result is still queued (keeps program order).
        push = exe_live && (mult_live || !fifo_empty);

        count_d  = count_q + {1'b0, push} - {1'b0, pop};
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;

        fifo_data_d = fifo_data_q;
        fifo_addr_d = fifo_addr_q;
        fifo_pc_d   = fifo_pc_q;
        if (push) begin
            fifo_data_d[wr_ptr_q] = bus.exe_int_write_data_i;
            fifo_addr_d[wr_ptr_q] = bus.exe_write_addr_i;
            fifo_pc_d[wr_ptr_q]   = bus.exe_pc_i;
        end

        rf_we_d   = 1'b0;
        rf_data_d = '0;
        rf_addr_d = '0;
        wb_pc_d   = '0;
        if (mult_live) begin
            rf_we_d   = 1'b1;
            rf_data_d = bus.mult_int_write_data_i;
            rf_addr_d = bus.mult_write_addr_i;
            wb_pc_d   = bus.mult_pc_i;
        end else if (!fifo_empty) begin
            rf_we_d   = 1'b1;
            rf_data_d = fifo_data_q[rd_ptr_q];
            rf_addr_d = fifo_addr_q[rd_ptr_q];
            wb_pc_d   = fifo_pc_q[rd_ptr_q];
        end else if (exe_live) begin
            rf_we_d   = 1'b1;
            rf_data_d = bus.exe_int_write_data_i;
            rf_addr_d = bus.exe_write_addr_i;
            wb_pc_d   = bus.exe_pc_i;
        end
    end

    // Control state and the registered write port
    always_ff @(posedge clk_i) begin
        if (rsn_i) begin
            count_q   <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            rf_we_q   <= 1'b0;
            rf_data_q <= '0;
            rf_addr_q <= '0;
            wb_pc_q   <= '0;
        end else begin
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rf_we_q   <= rf_we_d;
            rf_data_q <= rf_data_d;
            rf_addr_q <= rf_addr_d;
            wb_pc_q   <= wb_pc_d;
        end
    end

    // FIFO storage needs no reset: occupancy and pointers define validity.
    always_ff @(posedge clk_i) begin
        fifo_data_q <= fifo_data_d;
        fifo_addr_q <= fifo_addr_d;
        fifo_pc_q   <= fifo_pc_d;
    end

    assign bus.rf_write_data_o   = rf_data_q;
    assign bus.rf_write_addr_o   = rf_addr_q;
    assign bus.rf_write_enable_o = rf_we_q;
    assign bus.wb_pc_o           = wb_pc_q;
    assign bus.exe_stall_o       = stall;

endmodule

// File: tb/tb_mult_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mult_wb_arbiter
// Directed bench for mult_wb_arbiter. A queue-based reference model predicts
// the write port every cycle; directed sequences also pin literal values.
// ---------------------------------------------------------------------------
module tb_mult_wb_arbiter;
    logic clk;
    logic rsn;

    mult_wb_arbiter_if bus ();

    mult_wb_arbiter dut (
        .clk_i (clk),
        .rsn_i (rsn),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  addr;
        logic [31:0] pc;
    } ent_t;

    ent_t        q[$];
    logic        exp_we;
    logic [31:0] exp_data;
    logic [4:0]  exp_addr;
    logic [31:0] exp_pc;
    logic        exp_stall;
    bit          started = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference model: write port as a priority choice, buffer as a queue.
    always @(posedge clk) begin
        ent_t m;
        ent_t e;
        bit   m_live;
        bit   e_live;
        m = '{bus.mult_int_write_data_i, bus.mult_write_addr_i, bus.mult_pc_i};
        e = '{bus.exe_int_write_data_i, bus.exe_write_addr_i, bus.exe_pc_i};
        exp_we = 1'b0; exp_data = '0; exp_addr = '0; exp_pc = '0;
        if (rsn) begin
            q.delete();
        end else begin
            m_live = bus.mult_int_write_enable_i && bus.mult_write_addr_i != 0;
            e_live = bus.exe_int_write_enable_i && bus.exe_write_addr_i != 0 && q.size() < 2;
            if (m_live) begin
                exp_we = 1'b1; exp_data = m.data; exp_addr = m.addr; exp_pc = m.pc;
                if (e_live) q.push_back(e);
            end else if (q.size() > 0) begin
                e_live = e_live; // keep order: oldest leaves before the new one joins
                exp_we = 1'b1; exp_data = q[0].data; exp_addr = q[0].addr; exp_pc = q[0].pc;
                void'(q.pop_front());
                if (e_live) q.push_back(e);
            end else if (e_live) begin
                exp_we = 1'b1; exp_data = e.data; exp_addr = e.addr; exp_pc = e.pc;
            end
        end
        exp_stall = (q.size() == 2);
        started = 1;
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (started) begin
            chk("model_we",    32'(bus.rf_write_enable_o), 32'(exp_we));
            chk("model_data",  bus.rf_write_data_o,        exp_data);
            chk("model_addr",  32'(bus.rf_write_addr_o),   32'(exp_addr));
            chk("model_pc",    bus.wb_pc_o,                exp_pc);
            chk("model_stall", 32'(bus.exe_stall_o),       32'(exp_stall));
        end
    end

    task automatic set_in(input logic me, input logic [4:0] ma, input logic [31:0] md, input logic [31:0] mp,
                          input logic ee, input logic [4:0] ea, input logic [31:0] ed, input logic [31:0] ep);
        bus.mult_int_write_enable_i = me;
        bus.mult_write_addr_i       = ma;
        bus.mult_int_write_data_i   = md;
        bus.mult_pc_i               = mp;
        bus.exe_int_write_enable_i  = ee;
        bus.exe_write_addr_i        = ea;
        bus.exe_int_write_data_i    = ed;
        bus.exe_pc_i                = ep;
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input string name, input logic [4:0] a, input logic [31:0] d, input logic st);
        chk({name, "_we"},    32'(bus.rf_write_enable_o), 32'd1);
        chk({name, "_addr"},  32'(bus.rf_write_addr_o),   32'(a));
        chk({name, "_data"},  bus.rf_write_data_o,        d);
        chk({name, "_stall"}, 32'(bus.exe_stall_o),       32'(st));
    endtask

    task automatic expect_none(input string name);
        chk({name, "_we"},    32'(bus.rf_write_enable_o), 32'd0);
        chk({name, "_addr"},  32'(bus.rf_write_addr_o),   32'd0);
        chk({name, "_data"},  bus.rf_write_data_o,        32'd0);
        chk({name, "_pc"},    bus.wb_pc_o,                32'd0);
        chk({name, "_stall"}, 32'(bus.exe_stall_o),       32'd0);
    endtask

    initial begin
        rsn = 1'b1;
        idle();
        step();
        step();
        expect_none("reset");
        rsn = 1'b0;

        // Execute alone goes straight through.
        set_in(0, 0, 0, 0, 1, 5, 32'h11, 32'h100);
        step();
        expect_wr("exe_only", 5, 32'h11, 0);
        chk("exe_only_pc", bus.wb_pc_o, 32'h100);
        idle();
        step();
        expect_none("exe_only_after");

        // Collision: multiplier first, execute one cycle later.
        set_in(1, 3, 32'hAA, 32'h200, 1, 4, 32'hBB, 32'h204);
        step();
        expect_wr("coll_mult", 3, 32'hAA, 0);
        idle();
        step();
        expect_wr("coll_exe", 4, 32'hBB, 0);
        chk("coll_exe_pc", bus.wb_pc_o, 32'h204);
        step();
        expect_none("coll_done");

        // Fill the buffer, stall, then drain in order.
        set_in(1, 1, 32'h1, 32'h300, 1, 10, 32'hE1, 32'h400);
        step();
        expect_wr("full_a", 1, 32'h1, 0);
        set_in(1, 2, 32'h2, 32'h304, 1, 11, 32'hE2, 32'h404);
        step();
        expect_wr("full_b", 2, 32'h2, 1);
        set_in(1, 3, 32'h3, 32'h308, 1, 12, 32'hE3, 32'h408);
        step();
        expect_wr("full_c", 3, 32'h3, 1);
        set_in(0, 0, 0, 0, 1, 12, 32'hE3, 32'h408);
        step();
        expect_wr("full_d", 10, 32'hE1, 0);
        step();
        expect_wr("full_e", 11, 32'hE2, 0);
        idle();
        step();
        expect_wr("full_f", 12, 32'hE3, 0);
        chk("full_f_pc", bus.wb_pc_o, 32'h408);
        step();
        expect_none("full_done");

        // Non-live inputs are discarded.
        set_in(0, 7, 32'h77, 32'h500, 1, 0, 32'h55, 32'h504);
        step();
        expect_none("discard");
        idle();
        step();
        expect_none("discard_after");

        // Reset with two buffered entries and live inputs in the reset cycle.
        set_in(1, 1, 32'h10, 32'h600, 1, 5, 32'h50, 32'h700);
        step();
        set_in(1, 2, 32'h20, 32'h604, 1, 6, 32'h60, 32'h704);
        step();
        chk("rst_pre_stall", 32'(bus.exe_stall_o), 32'd1);
        rsn = 1'b1;
        set_in(1, 3, 32'h30, 32'h608, 1, 7, 32'h70, 32'h708);
        step();
        expect_none("rst_mid");
        rsn = 1'b0;
        idle();
        step();
        expect_none("rst_after1");
        step();
        expect_none("rst_after2");

        // Alternating collision/drain walks both pointers through wrap.
        for (int i = 0; i < 5; i++) begin
            set_in(1, 1, 32'h1000 + i, 32'h2000 + 4 * i, 1, 5'(2 + i), 32'hE000 + i, 32'h3000 + 4 * i);
            step();
            expect_wr("wrap_mult", 1, 32'h1000 + i, 0);
            idle();
            step();
            expect_wr("wrap_exe", 5'(2 + i), 32'hE000 + i, 0);
            chk("wrap_exe_pc", bus.wb_pc_o, 32'h3000 + 4 * i);
        end
        step();
        expect_none("wrap_done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mult_wb_arbiter.md
MULT_WB_ARBITER -- requirements
Module: mult_wb_arbiter

Interface
REQ-001 Parameters: none; data width fixed at 32, FIFO depth fixed at 2.
REQ-002 clk_i  in  1  sole clock, all state on rising edge.
REQ-003 rsn_i  in  1  synchronous reset, active-high (1 = reset), sampled on clk_i rising edge.
REQ-004 mult_int_write_data_i  in  32  result from last multiplier stage.
REQ-005 mult_write_addr_i  in  5  destination register of multiplier result.
REQ-006 mult_int_write_enable_i  in  1  multiplier result valid and must be written.
REQ-007 mult_pc_i  in  32  PC of multiplier instruction.
REQ-008 exe_int_write_data_i  in  32  result from single-cycle execute path.
REQ-009 exe_write_addr_i  in  5  destination register of execute result.
REQ-010 exe_int_write_enable_i  in  1  execute result valid and must be written.
REQ-011 exe_pc_i  in  32  PC of execute instruction.
REQ-012 rf_write_data_o  out  32  register-file write data.
REQ-013 rf_write_addr_o  out  5  register-file write address.
REQ-014 rf_write_enable_o  out  1  register-file write strobe.
REQ-015 wb_pc_o  out  32  PC of instruction being written back.
REQ-016 exe_stall_o  out  1  execute stage must hold its outputs this cycle.

Function
REQ-017 Block SHALL arbitrate one register-file write port between multiplier and execute results.
REQ-018 An input SHALL be "live" only if its write enable is 1 and its write address is non-zero; non-live inputs SHALL be discarded (never buffered, never written).
REQ-019 Execute inputs SHALL be ignored in any cycle where exe_stall_o is 1 (upstream holds them).
REQ-020 Block SHALL contain a 2-entry FIFO of execute results {data, addr, pc}, with 2-bit occupancy count (0..2).
REQ-021 Port grant priority per cycle: live mult input first; else FIFO head; else live exe input directly; else no write.
REQ-022 A live exe input SHALL be pushed into FIFO when mult input is live or FIFO is non-empty, preserving execute program order.
REQ-023 FIFO SHALL pop its head only when mult input is not live; push and pop in the same cycle SHALL leave count unchanged.
REQ-024 exe_stall_o SHALL be combinational from registered state: 1 iff count == 2.
REQ-025 Count SHALL never exceed 2; push is impossible while exe_stall_o is 1 (REQ-019).
REQ-026 Granted write SHALL appear on rf_write_* and wb_pc_o registered, exactly one cycle after the inputs are sampled (or after the FIFO pop decision).
REQ-027 In cycles with no grant, rf_write_enable_o SHALL be 0, and rf_write_data_o, rf_write_addr_o and wb_pc_o SHALL be 0.
REQ-028 FIFO read/write pointers SHALL be 1 bit each and wrap 1 -> 0.

Reset
REQ-029 While rsn_i is 1 at a clock edge: count, pointers and all outputs SHALL become 0; exe_stall_o SHALL be 0 on the following cycle.
REQ-030 Reset mid-operation SHALL discard all buffered entries without writing them; inputs in the reset cycle SHALL be dropped.
REQ-031 First grant after reset SHALL come from inputs sampled on the first edge with rsn_i = 0.

Verification
REQ-032 Exe only: exe addr 5, data 0x11, en 1, mult idle -> next cycle rf_write_enable_o 1, addr 5, data 0x11; stall 0.
REQ-033 Collision: mult addr 3 data 0xAA and exe addr 4 data 0xBB same cycle -> cycle+1 writes r3 = 0xAA, cycle+2 writes r4 = 0xBB; count 1 then 0.
REQ-034 Full: mult live three consecutive cycles with exe live on the first two -> count reaches 2, exe_stall_o 1, third exe value held upstream is not accepted until mult goes idle; exe results then written in original order.
REQ-035 Discard: exe en 1 with addr 0, and mult en 0 with addr 7 -> no write, count stays 0.
REQ-036 Reset mid-operation: count = 2, assert rsn_i one cycle -> outputs 0, count 0, stall 0; buffered entries never appear on rf_write_*.
REQ-037 Pointer wrap: 5 alternating collision/drain sequences -> every exe result written exactly once, in order, no loss or duplication.
